apb_slave_regfile: RTL

- APB responder (completer) for the team's 8-bit APB bus: decodes one select, captures the setup phase, and inserts a programmable number of wait states.
- Completes reads and writes against a bank of NUM_REGS 8-bit registers; flags out-of-range and protocol-violating accesses with pslverr.
- Pairs with the existing APB master on the same bus. Register contents are exported flat for downstream logic.

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_slave_regfile_if.sv | 25 ++
 rtl/apb_slave_regfile_regbank.sv | 44 ++++
 rtl/apb_slave_regfile.sv | 130 +++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths and the state encodings of both the
// master and the responder, so the two sides decode from one source.
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    typedef enum logic {
        APB_S_IDLE   = 1'b0,
        APB_S_ACCESS = 1'b1
    } apb_s_state_e;

    typedef enum logic [1:0] {
        APB_M_IDLE   = 2'b00,
        APB_M_SETUP  = 2'b01,
        APB_M_ACCESS = 2'b10
    } apb_m_state_e;

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle for the 8-bit team bus; master drives the request side,
// the responder drives the completion side.
interface apb_slave_regfile_if;
    import apb_pkg::*;

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [APB_ADDR_W-1:0] paddr;
    logic [APB_DATA_W-1:0] pwdata;
    logic [APB_DATA_W-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_slave_regfile_regbank.sv
// Register storage for the APB responder: NUM_REGS x 8-bit flops with a
// synchronous write port, a combinational read mux and a flat export.
module apb_regbank
    import apb_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           wr_en_i,
    input  logic [APB_ADDR_W-1:0]          wr_addr_i,
    input  logic [APB_DATA_W-1:0]          wr_data_i,
    input  logic [APB_ADDR_W-1:0]          rd_addr_i,
    output logic [APB_DATA_W-1:0]          rd_data_o,
    output logic [APB_DATA_W*NUM_REGS-1:0] reg_out_o
);

    logic [APB_DATA_W-1:0] regs_q [NUM_REGS];

    // NOTE: the bank is reset like ordinary flops (not left as an uninitialised
    // RAM) because downstream logic consumes reg_out from the first cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en_i && (wr_addr_i == APB_ADDR_W'(i))) regs_q[i] <= wr_data_i;
            end
        end
    end

    // Out-of-range addresses fall through to zero; the caller flags them.
    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr_i == APB_ADDR_W'(i)) rd_data_o = regs_q[i];
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_out_o[APB_DATA_W*g +: APB_DATA_W] = regs_q[g];
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB responder: captures the setup phase, inserts WAIT_CYCLES wait states,
// and completes reads/writes against apb_regbank with pslverr on bad accesses.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int NUM_REGS    = 16,
    parameter int WAIT_CYCLES = 1,
    parameter int CNT_W       = 4
) (
    input  logic                           clk,
    input  logic                           resetn,
    apb_slave_regfile_if.slave             apb,
    output logic [APB_DATA_W*NUM_REGS-1:0] reg_out
);

    localparam logic [CNT_W-1:0]      WAIT_LIM = CNT_W'(WAIT_CYCLES);
    localparam logic [APB_ADDR_W:0]   ADDR_LIM = (APB_ADDR_W + 1)'(NUM_REGS);

    apb_s_state_e          state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [APB_ADDR_W-1:0] addr_q, addr_d;
    logic [APB_DATA_W-1:0] wdata_q, wdata_d;
    logic                  write_q, write_d;

    logic                  wr_en;
    logic                  in_range;
    logic [APB_DATA_W-1:0] rd_data;
    logic                  pready_c;
    logic                  pslverr_c;
    logic [APB_DATA_W-1:0] prdata_c;

    assign in_range = ({1'b0, addr_q} < ADDR_LIM);

    // NOTE: state flops use non-blocking assignments so every register samples
    // the pre-edge values; the combinational process below uses blocking ones.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= APB_S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
        end
    end

    // NOTE: every output of this block is defaulted first so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        wr_en     = 1'b0;
        pready_c  = 1'b0;
        pslverr_c = 1'b0;
        prdata_c  = '0;

        case (state_q)
            APB_S_IDLE: begin
                if (apb.psel && !apb.penable) begin
                    addr_d  = apb.paddr;
                    wdata_d = apb.pwdata;
                    write_d = apb.pwrite;
                    cnt_d   = '0;
                    state_d = APB_S_ACCESS;
                end else if (apb.psel && apb.penable) begin
                    pready_c  = 1'b1;
                    pslverr_c = 1'b1;
                end
            end
            APB_S_ACCESS: begin
                if (!apb.psel) begin
                    cnt_d   = '0;
                    state_d = APB_S_IDLE;
                end else if (!apb.penable) begin
                    // A fresh setup replaces the pending transfer.
                    addr_d  = apb.paddr;
                    wdata_d = apb.pwdata;
                    write_d = apb.pwrite;
                    cnt_d   = '0;
                end else if (cnt_q != WAIT_LIM) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    pready_c  = 1'b1;
                    pslverr_c = !in_range;
                    wr_en     = write_q && in_range;
                    prdata_c  = (!write_q && in_range) ? rd_data : '0;
                    cnt_d     = '0;
                    state_d   = APB_S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = APB_S_IDLE;
            end
        endcase

        // Keep the bus quiet while reset is held, whatever the master drives.
        if (!resetn) begin
            pready_c  = 1'b0;
            pslverr_c = 1'b0;
            prdata_c  = '0;
        end
    end

    assign apb.pready  = pready_c;
    assign apb.pslverr = pslverr_c;
    assign apb.prdata  = prdata_c;

    apb_regbank #(
        .NUM_REGS (NUM_REGS)
    ) u_regbank (
        .clk       (clk),
        .resetn    (resetn),
        .wr_en_i   (wr_en),
        .wr_addr_i (addr_q),
        .wr_data_i (wdata_q),
        .rd_addr_i (addr_q),
        .rd_data_o (rd_data),
        .reg_out_o (reg_out)
    );

endmodule
